clk_div_sched: RTL



---
 rtl/clk_div_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// Purpose : NUM_CH runtime-reconfigurable clock dividers, each with a rising-edge tick.
// Latency : cfg_done one cycle after acceptance (disabled/unknown target), else at the next 1->0 boundary (<= 2*H_old).
// Backpr. : single pending slot; cfg_ready drops while a request waits, and cfg_valid is ignored until it returns.
//
// Ports:
//   I_CLK, rst            system clock (rising edge), synchronous active-high reset
//   cfg_valid/cfg_ready   request handshake; cfg_ch, cfg_half (0 treated as 1), cfg_en carry the request
//   cfg_done              one-cycle pulse in the cycle the request has taken effect
//   O_CLK, O_TICK         registered divided clocks and their first-high-cycle pulses
//   ch_running            current enable of each channel
module clk_div_sched #(
    parameter int                NUM_CH       = 4,
    parameter int                CNT_W        = 16,
    parameter int                DEFAULT_HALF = 1,
    parameter logic [NUM_CH-1:0] DEFAULT_EN   = {NUM_CH{1'b1}}
) (
    input  logic              I_CLK,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              cfg_en,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic [NUM_CH-1:0] O_CLK,
    output logic [NUM_CH-1:0] O_TICK,
    output logic [NUM_CH-1:0] ch_running
);

    localparam logic [CNT_W-1:0] RST_HALF = (DEFAULT_HALF < 1) ? CNT_W'(1) : CNT_W'(DEFAULT_HALF);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_half [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;
    logic              r_done;

    logic [2:0]        r_pend_ch;
    logic [CNT_W-1:0]  r_pend_half;
    logic              r_pend_en;

    logic              w_ready;
    logic              w_accept;
    logic              w_apply;
    logic              w_boundary;
    logic [NUM_CH-1:0] w_wrap;   // channel is in the last cycle of its current phase
    logic [NUM_CH-1:0] w_sel;    // one-hot decode of the pending target

    always_comb begin
        w_wrap = '0;
        w_sel  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wrap[i] = r_en[i] && (r_cnt[i] == (r_half[i] - CNT_W'(1)));
            w_sel[i]  = (r_pend_ch == 3'(i));
        end
        // A target outside the channel range decodes to nothing and applies at once;
        // otherwise wait until the channel is stopped or its high phase is ending.
        w_boundary = (w_sel == '0) || ((w_sel & (~r_en | (w_wrap & r_clk))) != '0);
    end

    // Config FSM: state register
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Config FSM: next state and handshake
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cfg_valid) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_boundary) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = cfg_valid && w_ready;

    // Pending slot
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            r_pend_ch   <= '0;
            r_pend_half <= '0;
            r_pend_en   <= 1'b0;
        end else if (w_accept) begin
            r_pend_ch   <= cfg_ch;
            r_pend_half <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
            r_pend_en   <= cfg_en;
        end
    end

    // Channel counters and divided clocks
    always_ff @(posedge I_CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                r_cnt[i]  <= '0;
                r_half[i] <= RST_HALF;
                r_en[i]   <= DEFAULT_EN[i];
                r_clk[i]  <= 1'b0;
                r_tick[i] <= 1'b0;
            end else if (w_apply && w_sel[i]) begin
                // Restart from the start of a low phase with the new settings.
                r_cnt[i]  <= '0;
                r_clk[i]  <= 1'b0;
                r_tick[i] <= 1'b0;
                r_half[i] <= r_pend_half;
                r_en[i]   <= r_pend_en;
            end else if (r_en[i]) begin
                r_tick[i] <= w_wrap[i] && !r_clk[i];
                if (w_wrap[i]) begin
                    r_cnt[i] <= '0;
                    r_clk[i] <= ~r_clk[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end else begin
                r_cnt[i]  <= '0;
                r_clk[i]  <= 1'b0;
                r_tick[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_apply;
        end
    end

    assign cfg_ready  = w_ready;
    assign cfg_done   = r_done;
    assign O_CLK      = r_clk;
    assign O_TICK     = r_tick;
    assign ch_running = r_en;

endmodule
